sram_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that sequences the 1r1w 256x32 OpenRAM macro (custom_sram_1r1w_32_256_freepdk45) as FIFO storage.
- Drives the macro's write port (port 0) and read port (port 1) from one clock.
- Presents valid/ready push and pop interfaces with first-word-fall-through output.
- Hides the macro's registered-address, negedge-access read latency behind a 2-entry output staging buffer.

---
 rtl/sram_fifo_ctrl_if.sv | 27 ++
 rtl/sram_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_sram_fifo_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_fifo_ctrl_if.sv
// Push/pop handshake bundle for sram_fifo_ctrl.
//   in_valid/in_ready/in_data     : push side, word accepted when valid & ready
//   out_valid/out_ready/out_data  : pop side, first-word-fall-through head word
//   level                         : total words held (SRAM + in flight + staged)
// master : the client that pushes and pops; slave : the FIFO controller.
interface sram_fifo_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH+1:0] level;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, level
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, level
   );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Single-clock FIFO controller using a 1r1w OpenRAM macro as storage.
//   clk_i    : clock, also clocks the macro's clk0/clk1 at the level above
//   rstb_i   : synchronous reset, active-low
//   flush_i  : synchronous clear of all contents, active-high
//   fifo_if  : push/pop handshake bundle (slave side) plus occupancy level
//   csb0_o, addr0_o, din0_o : macro write port (port 0)
//   csb1_o, addr1_o, dout1_i: macro read port (port 1)
// The macro registers its read address and returns data one cycle later, so a
// 2-entry staging buffer holds captured words and presents the head as out_data.
// DEPTH must equal 1 << ADDR_WIDTH so the pointers wrap naturally.
module sram_fifo_ctrl #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rstb_i,
   input  logic                  flush_i,
   sram_fifo_ctrl_if.slave       fifo_if,
   output logic                  csb0_o,
   output logic [ADDR_WIDTH-1:0] addr0_o,
   output logic [DATA_WIDTH-1:0] din0_o,
   output logic                  csb1_o,
   output logic [ADDR_WIDTH-1:0] addr1_o,
   input  logic [DATA_WIDTH-1:0] dout1_i
);

   localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
   logic                  inflight_q, inflight_d;
   logic [1:0]            staged_q, staged_d;
   logic [DATA_WIDTH-1:0] stg_q [2];
   logic [DATA_WIDTH-1:0] stg_d [2];

   logic active, in_ready, push, pop, issue;

   // Reset and flush both gate every request in the cycle they are asserted.
   assign active   = rstb_i & ~flush_i;
   assign in_ready = active & (sram_cnt_q < DepthCnt);
   assign push     = fifo_if.in_valid & in_ready;
   assign pop      = (staged_q != 2'd0) & fifo_if.out_ready;

   // Issue a read only if the staging buffer can absorb it once it lands:
   // staged + inflight - pop < 2.
   assign issue = active & (sram_cnt_q != '0) &
                  (({1'b0, staged_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

   always_comb begin
      logic [1:0] cnt;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      sram_cnt_d = sram_cnt_q;
      inflight_d = issue;
      stg_d      = stg_q;
      cnt        = staged_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue) rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({push, issue})
         2'b10:   sram_cnt_d = sram_cnt_q + 1'b1;
         2'b01:   sram_cnt_d = sram_cnt_q - 1'b1;
         default: sram_cnt_d = sram_cnt_q;
      endcase

      // Pop shifts the buffer first so a same-cycle capture lands behind the
      // surviving entry.
      if (pop) begin
         stg_d[0] = stg_q[1];
         cnt      = cnt - 1'b1;
      end
      // dout1 is only valid around this edge; the macro drives junk after hold.
      if (inflight_q) begin
         stg_d[cnt[0]] = dout1_i;
         cnt           = cnt + 1'b1;
      end
      staged_d = cnt;
   end

   always_ff @(posedge clk_i) begin
      if (!rstb_i || flush_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
         staged_q   <= 2'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         sram_cnt_q <= sram_cnt_d;
         inflight_q <= inflight_d;
         staged_q   <= staged_d;
      end
   end

   // Data storage needs no reset; staged_q qualifies it.
   always_ff @(posedge clk_i) begin
      stg_q <= stg_d;
   end

   assign fifo_if.in_ready  = in_ready;
   assign fifo_if.out_valid = (staged_q != 2'd0);
   assign fifo_if.out_data  = stg_q[0];
   assign fifo_if.level     = {1'b0, sram_cnt_q} + (ADDR_WIDTH + 2)'(inflight_q) +
                              (ADDR_WIDTH + 2)'(staged_q);

   assign csb0_o  = ~push;
   assign addr0_o = wr_ptr_q;
   assign din0_o  = fifo_if.in_data;
   assign csb1_o  = ~issue;
   assign addr1_o = rd_ptr_q;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl: directed vector table plus multi-cycle sequences,
// with a behavioural model of the 1r1w macro and an in-order scoreboard.
module tb_sram_fifo_ctrl;
   localparam int DW    = 32;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk   = 1'b0;
   logic          rstb  = 1'b0;
   logic          flush = 1'b0;
   logic          csb0, csb1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] din0;
   logic [DW-1:0] dout1 = '0;

   sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo_if ();

   sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk_i   (clk),
      .rstb_i  (rstb),
      .flush_i (flush),
      .fifo_if (fifo_if),
      .csb0_o  (csb0),
      .addr0_o (addr0),
      .din0_o  (din0),
      .csb1_o  (csb1),
      .addr1_o (addr1),
      .dout1_i (dout1)
   );

   always #5 clk = ~clk;

   // Macro model: ports registered at posedge, access at negedge + 1,
   // read data replaced by junk 1 unit after the next posedge.
   logic [DW-1:0] mem [DEPTH];
   logic          wcs_q = 1'b1, rcs_q = 1'b1;
   logic [AW-1:0] wa_q, ra_q;
   logic [DW-1:0] wd_q;

   always @(posedge clk) begin
      wcs_q <= csb0; wa_q <= addr0; wd_q <= din0;
      rcs_q <= csb1; ra_q <= addr1;
   end
   always begin
      @(negedge clk);
      #1;
      if (!wcs_q) mem[wa_q] = wd_q;
      if (!rcs_q) dout1 = mem[ra_q];
   end
   always begin
      @(posedge clk);
      #1;
      dout1 = 32'hBAD0_BAD0;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor, sampled at negedge.
   logic [DW-1:0] sb [$];
   int pop_cnt = 0, first_pop = 0, last_pop = 0, cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (!csb0 && !csb1) check("addr_conflict", 64'(addr0 == addr1), 64'd0);
      if (!rstb || flush) begin
         sb.delete();
      end else begin
         if (fifo_if.out_valid && fifo_if.out_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL pop_unexpected: got 0x%0h, expected no pop", fifo_if.out_data);
            end else begin
               check("pop_order", fifo_if.out_data, sb.pop_front());
            end
            pop_cnt++;
            if (pop_cnt == 1) first_pop = cyc;
            last_pop = cyc;
         end
         if (fifo_if.in_valid && fifo_if.in_ready) sb.push_back(fifo_if.in_data);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rstb, flush, iv;
      logic [31:0] din;
      logic        ordy;
      logic        e_irdy, e_ov;
      logic [31:0] e_dout;
      logic [9:0]  e_lvl;
      logic        e_csb0;
      logic [7:0]  e_a0;
      logic        e_csb1;
      logic [7:0]  e_a1;
   } vec_t;

   vec_t vecs [12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] d);
      bit ok;
      ok = 1'b0;
      fifo_if.in_valid = 1'b1;
      fifo_if.in_data  = d;
      for (int n = 0; n < 600 && !ok; n++) begin
         @(negedge clk);
         ok = fifo_if.in_ready;
         step();
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: word 0x%0h not accepted, expected acceptance", d);
      end
   endtask

   task automatic wait_empty(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         @(negedge clk);
         done = (fifo_if.level == '0);
         step();
      end
      check({name, "_drained"}, 64'(done), 64'd1);
   endtask

   task automatic flush_case(input bit use_rst, input string tag);
      bit seen;
      pop_cnt = 0;
      fifo_if.out_ready = 1'b0;
      for (int i = 1; i <= 10; i++) push_word(32'h100 + i);
      fifo_if.in_valid = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check({tag, "_level10"}, fifo_if.level, 64'd10);
      step();
      fifo_if.out_ready = 1'b1;      // pop head, which triggers a read issue
      step();
      fifo_if.out_ready = 1'b0;
      fifo_if.in_valid  = 1'b1;      // must be blocked by the clear
      fifo_if.in_data   = 32'hDEAD_0000;
      if (use_rst) rstb = 1'b0;
      else flush = 1'b1;
      @(negedge clk);
      check({tag, "_pre_level"}, fifo_if.level, 64'd9);
      check({tag, "_irdy_gated"}, 64'(fifo_if.in_ready), 64'd0);
      check({tag, "_csb0_gated"}, 64'(csb0), 64'd1);
      check({tag, "_csb1_gated"}, 64'(csb1), 64'd1);
      step();
      rstb = 1'b1;
      flush = 1'b0;
      fifo_if.in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_level0"}, fifo_if.level, 64'd0);
      check({tag, "_ov0"}, 64'(fifo_if.out_valid), 64'd0);
      step();
      @(negedge clk);
      check({tag, "_no_late_cap"}, 64'(fifo_if.out_valid), 64'd0);
      step();
      fifo_if.out_ready = 1'b0;
      push_word(32'h1234);
      fifo_if.in_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge clk);
         seen = fifo_if.out_valid;
         if (seen) check({tag, "_first_word"}, fifo_if.out_data, 64'h1234);
         step();
      end
      check({tag, "_ov_seen"}, 64'(seen), 64'd1);
      fifo_if.out_ready = 1'b1;
      wait_empty(tag, 20);
   endtask

   initial begin
      int cnt, sent;
      bit acc, done;

      //            rstb  fl    iv    din            ordy  irdy  ov    dout           lvl    csb0  a0    csb1  a1
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0,         10'd0, 1'b1, 8'd0, 1'b1, 8'd0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         10'd0, 1'b1, 8'd0, 1'b1, 8'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0,         10'd0, 1'b0, 8'd0, 1'b1, 8'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         10'd1, 1'b1, 8'd0, 1'b0, 8'd0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         10'd1, 1'b1, 8'd0, 1'b1, 8'd0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 10'd1, 1'b1, 8'd0, 1'b1, 8'd0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         10'd0, 1'b1, 8'd0, 1'b1, 8'd0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h11,        1'b0, 1'b1, 1'b0, 32'h0,         10'd0, 1'b0, 8'd1, 1'b1, 8'd0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h22,        1'b0, 1'b1, 1'b0, 32'h0,         10'd1, 1'b0, 8'd2, 1'b0, 8'd1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h33,        1'b1, 1'b0, 1'b0, 32'h0,         10'd2, 1'b1, 8'd0, 1'b1, 8'd0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         10'd0, 1'b1, 8'd0, 1'b1, 8'd0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h44,        1'b1, 1'b1, 1'b0, 32'h0,         10'd0, 1'b0, 8'd0, 1'b1, 8'd0};

      fifo_if.in_valid  = 1'b0;
      fifo_if.in_data   = '0;
      fifo_if.out_ready = 1'b0;
      rstb = 1'b0;
      repeat (2) step();

      // Reset, latency, simple flush.
      for (int i = 0; i < 12; i++) begin
         rstb              = vecs[i].rstb;
         flush             = vecs[i].flush;
         fifo_if.in_valid  = vecs[i].iv;
         fifo_if.in_data   = vecs[i].din;
         fifo_if.out_ready = vecs[i].ordy;
         @(negedge clk);
         check($sformatf("vec%0d_in_ready", i), 64'(fifo_if.in_ready), 64'(vecs[i].e_irdy));
         check($sformatf("vec%0d_out_valid", i), 64'(fifo_if.out_valid), 64'(vecs[i].e_ov));
         check($sformatf("vec%0d_level", i), fifo_if.level, vecs[i].e_lvl);
         check($sformatf("vec%0d_csb0", i), 64'(csb0), 64'(vecs[i].e_csb0));
         check($sformatf("vec%0d_csb1", i), 64'(csb1), 64'(vecs[i].e_csb1));
         if (vecs[i].e_ov) check($sformatf("vec%0d_out_data", i), fifo_if.out_data, vecs[i].e_dout);
         if (!vecs[i].e_csb0) check($sformatf("vec%0d_addr0", i), addr0, vecs[i].e_a0);
         if (!vecs[i].e_csb1) check($sformatf("vec%0d_addr1", i), addr1, vecs[i].e_a1);
         step();
      end
      flush = 1'b0;
      fifo_if.in_valid  = 1'b0;
      fifo_if.out_ready = 1'b1;
      wait_empty("table", 20);

      // Streaming 300 words: pointers wrap, one pop per cycle after the first.
      pop_cnt = 0;
      fifo_if.out_ready = 1'b1;
      for (int i = 1; i <= 300; i++) push_word(i);
      fifo_if.in_valid = 1'b0;
      wait_empty("stream", 50);
      check("stream_pops", pop_cnt, 64'd300);
      check("stream_gapless", last_pop - first_pop + 1, 64'd300);

      // Fill to full with no pops.
      pop_cnt = 0;
      cnt = 0;
      fifo_if.out_ready = 1'b0;
      fifo_if.in_valid  = 1'b1;
      fifo_if.in_data   = 32'd1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         acc = fifo_if.in_ready;
         if (acc) cnt++;
         step();
         if (!acc) break;
         fifo_if.in_data = cnt + 1;
      end
      fifo_if.in_valid = 1'b0;
      check("full_accepted", cnt, 64'd258);
      @(negedge clk);
      check("full_in_ready", 64'(fifo_if.in_ready), 64'd0);
      check("full_level", fifo_if.level, 64'd258);
      step();
      fifo_if.out_ready = 1'b1;
      @(negedge clk);
      check("full_irdy_hold", 64'(fifo_if.in_ready), 64'd0);
      step();
      @(negedge clk);
      check("full_irdy_back", 64'(fifo_if.in_ready), 64'd1);
      step();
      wait_empty("full", 400);
      check("full_pops", pop_cnt, 64'd258);

      // Backpressure: out_ready toggles each cycle during a 50-word stream.
      pop_cnt = 0;
      sent = 0;
      done = 1'b0;
      for (int c = 0; c < 500 && !done; c++) begin
         fifo_if.in_valid  = (sent < 50);
         fifo_if.in_data   = sent + 1;
         fifo_if.out_ready = (c % 2 == 0);
         @(negedge clk);
         if (fifo_if.in_valid && fifo_if.in_ready) sent++;
         done = (sent == 50) && (fifo_if.level == '0);
         step();
      end
      fifo_if.in_valid = 1'b0;
      check("bp_sent", sent, 64'd50);
      check("bp_pops", pop_cnt, 64'd50);

      // Clear with a read in flight, by flush then by reset.
      flush_case(1'b0, "flush");
      flush_case(1'b1, "reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
